// File: rtl/umem_arbiter.sv
// Unified memory port arbiter: data accesses win by default, fetch is forced
// after FAIR_MAX consecutive data grants, and a watchdog aborts stuck accesses.
module umem_arbiter #(
   parameter int unsigned AW       = 32,
   parameter int unsigned DW       = 32,
   parameter int unsigned TIMEOUT  = 16,
   parameter int unsigned FAIR_MAX = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic          i_done,
   output logic [DW-1:0] i_rdata,
   output logic          i_stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_done,
   output logic [DW-1:0] d_rdata,
   output logic          d_stall,
   output logic          err,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned FW = $clog2(FAIR_MAX + 1);
   localparam int unsigned TW = $clog2(TIMEOUT);
   localparam logic [FW-1:0] FAIR_LIM = FW'(FAIR_MAX);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DACC = 2'd1,
      IACC = 2'd2
   } state_t;

   state_t        state;
   logic [FW-1:0] fair_cnt;
   logic [TW-1:0] tmo_cnt;

   assign i_stall = i_req & ~i_done;
   assign d_stall = d_req & ~d_done;

   // Arbitration, access sequencing and completion reporting
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         fair_cnt  <= '0;
         tmo_cnt   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_done    <= 1'b0;
         d_done    <= 1'b0;
         err       <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_done <= 1'b0;
         d_done <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               // Requesters are still updating their request while done is high
               if (!(i_done || d_done)) begin
                  if (d_req && (!i_req || (fair_cnt < FAIR_LIM))) begin
                     state     <= DACC;
                     mem_req   <= 1'b1;
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                     fair_cnt  <= i_req ? (fair_cnt + FW'(1)) : '0;
                  end else if (i_req) begin
                     state    <= IACC;
                     mem_req  <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= i_addr;
                     fair_cnt <= '0;
                  end
               end
            end
            DACC, IACC: begin
               if (mem_ack) begin
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (state == IACC) begin
                     i_rdata <= mem_rdata;
                     i_done  <= 1'b1;
                  end else begin
                     if (!mem_we) d_rdata <= mem_rdata;
                     d_done <= 1'b1;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  // Aborted fetch returns zero, which decodes as a nop
                  state   <= IDLE;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  err     <= 1'b1;
                  if (state == IACC) begin
                     i_rdata <= '0;
                     i_done  <= 1'b1;
                  end else begin
                     if (!mem_we) d_rdata <= '0;
                     d_done <= 1'b1;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_umem_arbiter.sv
// Testbench for umem_arbiter: directed scenarios followed by randomized traffic
// checked against a request-level model of grant order and memory contents.
module tb_umem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_done;
   logic [31:0] i_rdata;
   logic        i_stall;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done;
   logic [31:0] d_rdata;
   logic        d_stall;
   logic        err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dev_mem [logic [31:0]];

   umem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .FAIR_MAX(3)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_stall(i_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall), .err(err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_req(input string tag);
      int k = 0;
      while (mem_req !== 1'b1 && k < 40) begin
         step();
         k++;
      end
      chk(tag, 32'(mem_req), 32'd1);
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction

   function automatic logic [31:0] dev_read(input logic [31:0] a);
      if (dev_mem.exists(a)) return dev_mem[a];
      return init_word(a);
   endfunction

   initial begin
      int          fair;
      int          cur;
      int          wcnt;
      int          ack_target;
      int          n_done;
      bit          i_pend;
      bit          d_pend;
      bit          snap_i;
      bit          snap_d;
      bit          prev_mreq;
      bit          exp_d;
      bit          hold_ok;
      logic [31:0] last_d;

      // Reset values
      step();
      step();
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_i_done", 32'(i_done), 32'd0);
      chk("rst_d_done", 32'(d_done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      reset = 1'b1;
      step();

      // 1: fetch only, ack two cycles after mem_req
      i_addr = 32'h0040_0000;
      i_req  = 1'b1;
      step();
      chk("t1_mem_req", 32'(mem_req), 32'd1);
      chk("t1_mem_addr", mem_addr, 32'h0040_0000);
      chk("t1_mem_we", 32'(mem_we), 32'd0);
      chk("t1_i_stall", 32'(i_stall), 32'd1);
      step();
      chk("t1_hold", 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h2008_0005;
      step();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      chk("t1_i_done", 32'(i_done), 32'd1);
      chk("t1_i_rdata", i_rdata, 32'h2008_0005);
      chk("t1_i_stall_done", 32'(i_stall), 32'd0);
      chk("t1_mem_req_drop", 32'(mem_req), 32'd0);
      i_req = 1'b0;
      step();
      chk("t1_done_pulse", 32'(i_done), 32'd0);

      // 2: simultaneous store and fetch, store first
      i_addr  = 32'h0040_0004;
      i_req   = 1'b1;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0010;
      d_wdata = 32'hDEAD_BEEF;
      step();
      chk("t2_mem_req", 32'(mem_req), 32'd1);
      chk("t2_mem_we", 32'(mem_we), 32'd1);
      chk("t2_mem_addr", mem_addr, 32'h0000_0010);
      chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("t2_d_stall", 32'(d_stall), 32'd1);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("t2_d_done", 32'(d_done), 32'd1);
      chk("t2_d_stall_done", 32'(d_stall), 32'd0);
      chk("t2_store_rdata", d_rdata, 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      step();
      chk("t2_gap", 32'(mem_req), 32'd0);
      step();
      chk("t2_fetch_req", 32'(mem_req), 32'd1);
      chk("t2_fetch_addr", mem_addr, 32'h0040_0004);
      chk("t2_fetch_we", 32'(mem_we), 32'd0);
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_2222;
      step();
      mem_ack = 1'b0;
      chk("t2_i_done", 32'(i_done), 32'd1);
      chk("t2_i_rdata", i_rdata, 32'h1111_2222);
      i_req = 1'b0;
      step();

      // 3: starvation, expect D,D,D,I repeating
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_0020;
      i_req  = 1'b1;
      i_addr = 32'h0040_0100;
      for (int g = 0; g < 8; g++) begin
         wait_req("t3_grant_wait");
         chk("t3_grant", mem_addr, ((g % 4) == 3) ? i_addr : d_addr);
         mem_ack   = 1'b1;
         mem_rdata = 32'hC0DE_0000 + 32'(g);
         step();
         mem_ack = 1'b0;
         if ((g % 4) == 3) chk("t3_i_done", 32'(i_done), 32'd1);
         else              chk("t3_d_done", 32'(d_done), 32'd1);
      end
      chk("t3_d_rdata", d_rdata, 32'hC0DE_0006);
      d_req = 1'b0;
      i_req = 1'b0;
      step();

      // 4: load timeout after 16 cycles of mem_req
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_0030;
      step();
      chk("t4_grant", 32'(mem_req), 32'd1);
      hold_ok = 1'b1;
      for (int k = 1; k < 16; k++) begin
         step();
         if (mem_req !== 1'b1 || d_done !== 1'b0) hold_ok = 1'b0;
      end
      chk("t4_hold_15", 32'(hold_ok), 32'd1);
      step();
      chk("t4_mem_req_drop", 32'(mem_req), 32'd0);
      chk("t4_d_done", 32'(d_done), 32'd1);
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_d_rdata_zero", d_rdata, 32'd0);
      d_addr = 32'h0000_0034;
      step();
      chk("t4_err_pulse", 32'(err), 32'd0);
      step();
      chk("t4_next_req", 32'(mem_req), 32'd1);
      chk("t4_next_addr", mem_addr, 32'h0000_0034);
      mem_ack   = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      step();
      mem_ack = 1'b0;
      chk("t4_next_done", 32'(d_done), 32'd1);
      chk("t4_next_err", 32'(err), 32'd0);
      chk("t4_next_rdata", d_rdata, 32'h0BAD_F00D);
      d_req = 1'b0;
      step();

      // 5: reset in the middle of a data access
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0040;
      d_wdata = 32'h1234_5678;
      step();
      chk("t5_grant", 32'(mem_req), 32'd1);
      step();
      #2;
      reset = 1'b0;
      #1;
      chk("t5_async_drop", 32'(mem_req), 32'd0);
      d_req = 1'b0;
      d_we  = 1'b0;
      step();
      chk("t5_no_done", 32'(d_done), 32'd0);
      chk("t5_no_err", 32'(err), 32'd0);
      reset = 1'b1;
      step();
      chk("t5_no_done_rel", 32'(d_done), 32'd0);
      chk("t5_idle", 32'(mem_req), 32'd0);
      i_addr = 32'h0040_0200;
      i_req  = 1'b1;
      step();
      chk("t5_fetch_req", 32'(mem_req), 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      step();
      mem_ack = 1'b0;
      chk("t5_fetch_done", 32'(i_done), 32'd1);
      chk("t5_fetch_rdata", i_rdata, 32'h5555_AAAA);
      i_req = 1'b0;
      step();

      // 6: stray ack while idle
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      step();
      step();
      chk("t6_i_done", 32'(i_done), 32'd0);
      chk("t6_d_done", 32'(d_done), 32'd0);
      chk("t6_mem_req", 32'(mem_req), 32'd0);
      chk("t6_i_rdata", i_rdata, 32'h5555_AAAA);
      chk("t6_d_rdata", d_rdata, 32'd0);
      mem_ack   = 1'b0;
      mem_rdata = '0;
      step();
      chk("t6_d_done_late", 32'(d_done), 32'd0);

      // Randomized traffic against the request-level model
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
      fair = 0; cur = 0; wcnt = 0; ack_target = 0; n_done = 0;
      i_pend = 1'b0; d_pend = 1'b0; snap_i = 1'b0; snap_d = 1'b0; prev_mreq = 1'b0;
      last_d = '0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         step();
         if (i_done) begin
            chk("rnd_i_owner", 32'(cur), 32'd2);
            chk("rnd_i_rdata", i_rdata, ref_read(i_addr));
            chk("rnd_i_err", 32'(err), 32'd0);
            i_pend = 1'b0;
            cur = 0;
            n_done++;
         end
         if (d_done) begin
            chk("rnd_d_owner", 32'(cur), 32'd1);
            if (!d_we) begin
               last_d = ref_read(d_addr);
               chk("rnd_load_rdata", d_rdata, last_d);
            end else begin
               ref_mem[d_addr] = d_wdata;
               chk("rnd_store_rdata", d_rdata, last_d);
            end
            chk("rnd_d_err", 32'(err), 32'd0);
            d_pend = 1'b0;
            cur = 0;
            n_done++;
         end
         if (mem_req && !prev_mreq) begin
            exp_d = snap_d && (!snap_i || fair < 3);
            chk("rnd_grant_overlap", 32'(cur), 32'd0);
            chk("rnd_grant_addr", mem_addr, exp_d ? d_addr : i_addr);
            chk("rnd_grant_we", 32'(mem_we), exp_d ? 32'(d_we) : 32'd0);
            fair = exp_d ? (snap_i ? fair + 1 : 0) : 0;
            cur = exp_d ? 1 : 2;
            ack_target = int'($urandom_range(0, 3));
            wcnt = 0;
         end
         if (mem_req && wcnt == ack_target) begin
            mem_ack = 1'b1;
            if (mem_we) dev_mem[mem_addr] = mem_wdata;
            else        mem_rdata = dev_read(mem_addr);
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) wcnt++;
         end
         if (!i_pend && cyc < 3600 && $urandom_range(0, 2) == 0) begin
            i_pend = 1'b1;
            i_addr = 32'h0040_0000 + ($urandom_range(0, 255) << 2);
         end
         if (!d_pend && cyc < 3600 && $urandom_range(0, 1) == 0) begin
            d_pend  = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = 32'h0000_0100 + ($urandom_range(0, 7) << 2);
            d_wdata = $urandom;
         end
         i_req     = i_pend;
         d_req     = d_pend;
         snap_i    = i_req;
         snap_d    = d_req;
         prev_mreq = mem_req;
      end
      chk("rnd_drain_cur", 32'(cur), 32'd0);
      chk("rnd_drain_pend", {30'd0, i_pend, d_pend}, 32'd0);
      chk("rnd_progress", 32'(n_done > 300), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
